// File: rtl/ext_sram_ctrl.sv
// ext_sram_ctrl: 32-bit strobe/ack bus slave driving a 16-bit asynchronous
// SRAM through two external address latches on a multiplexed address/data bus.
// Each access runs an address-latch phase, then two big-endian halfword phases
// (upper halfword first). The upper-address latch phase can be skipped when the
// upper address is unchanged, and data phases can be stretched with wait states.
module ext_sram_ctrl #(
  parameter int SRAM_LATCH_LAZY = 1,
  parameter int SRAM_STALL_CYC  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stb,
  input  logic        i_rw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_dtw,
  output logic [31:0] dtr,
  output logic        ack,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        douten,
  output logic        lat_hi,
  output logic        lat_lo,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n
);

  localparam logic [3:0] STALL_LAST = 4'(SRAM_STALL_CYC);

  typedef enum logic [2:0] {IDLE, LATH, LATL, DATA, DONE} state_t;

  state_t      state, state_nx;
  logic        rw_q;
  logic [31:2] addr_q;
  logic [31:0] dtw_q;
  logic        half;
  logic [15:0] hi_addr;
  logic        hi_valid;
  logic [3:0]  cnt;
  logic [15:0] dout_q;
  logic        skip_hi;
  logic        last_data;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^i_addr[1:0];

  assign skip_hi   = (SRAM_LATCH_LAZY != 0) && hi_valid && (i_addr[31:16] == hi_addr);
  assign last_data = (cnt == STALL_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and bus/strobe outputs; dout holds its previous value unless driven
  always_comb begin
    state_nx = state;
    lat_hi   = 1'b0;
    lat_lo   = 1'b0;
    ce_n     = 1'b1;
    oe_n     = 1'b1;
    we_n     = 1'b1;
    douten   = 1'b0;
    ack      = 1'b0;
    dout     = dout_q;
    case (state)
      IDLE: begin
        if (stb) state_nx = skip_hi ? LATL : LATH;
      end
      LATH: begin
        dout     = addr_q[31:16];
        douten   = 1'b1;
        lat_hi   = 1'b1;
        state_nx = LATL;
      end
      LATL: begin
        dout     = {addr_q[15:2], half, 1'b0};
        douten   = 1'b1;
        lat_lo   = 1'b1;
        ce_n     = 1'b0;
        state_nx = DATA;
      end
      DATA: begin
        ce_n = 1'b0;
        if (rw_q) begin
          we_n   = 1'b0;
          douten = 1'b1;
          dout   = half ? dtw_q[15:0] : dtw_q[31:16];
        end else begin
          oe_n = 1'b0;
        end
        if (last_data) state_nx = half ? DONE : LATL;
      end
      DONE: begin
        ack      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, upper-address tracking, wait-state count and read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q     <= 1'b0;
      addr_q   <= '0;
      dtw_q    <= '0;
      half     <= 1'b0;
      hi_addr  <= '0;
      hi_valid <= 1'b0;
      cnt      <= '0;
      dout_q   <= '0;
      dtr      <= '0;
    end else begin
      dout_q <= dout;
      case (state)
        IDLE: begin
          if (stb) begin
            rw_q   <= i_rw;
            addr_q <= i_addr[31:2];
            dtw_q  <= i_dtw;
            half   <= 1'b0;
            cnt    <= '0;
          end
        end
        LATH: begin
          hi_addr  <= addr_q[31:16];
          hi_valid <= 1'b1;
        end
        LATL: cnt <= '0;
        DATA: begin
          if (last_data) begin
            if (!rw_q) begin
              if (half) dtr[15:0]  <= din;
              else      dtr[31:16] <= din;
            end
            half <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Testbench for ext_sram_ctrl: three instances (lazy off / lazy on / lazy on
// with two wait states), each checked cycle by cycle against an expected bus
// trace built from the access rules.
module tb_ext_sram_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        stb[N], i_rw[N], ack[N], douten[N], lat_hi[N], lat_lo[N];
  logic        ce_n[N], oe_n[N], we_n[N];
  logic [31:0] i_addr[N], i_dtw[N], dtr[N];
  logic [15:0] din[N], dout[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    ext_sram_ctrl #(
      .SRAM_LATCH_LAZY((g == 0) ? 0 : 1),
      .SRAM_STALL_CYC ((g == 2) ? 2 : 0)
    ) dut (
      .clk(clk), .reset(reset), .stb(stb[g]), .i_rw(i_rw[g]),
      .i_addr(i_addr[g]), .i_dtw(i_dtw[g]), .dtr(dtr[g]), .ack(ack[g]),
      .din(din[g]), .dout(dout[g]), .douten(douten[g]),
      .lat_hi(lat_hi[g]), .lat_lo(lat_lo[g]),
      .ce_n(ce_n[g]), .oe_n(oe_n[g]), .we_n(we_n[g])
    );
  end

  // Reference state: last latched upper address, held read data and bus value
  bit          hv[N];
  logic [15:0] ha[N];
  logic [31:0] mdtr[N];
  logic [15:0] mdout[N];
  bit          fixed_din;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    bit lh, ll, ce, oe, we, en, ak;
    logic [15:0] d;
    bit dt, last, h;
  } cyc_t;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs(int k, string ph, bit lh, bit ll, bit ce, bit oe,
                          bit we, bit en, bit ak, logic [15:0] d);
    check($sformatf("%s.lat_hi[%0d]", ph, k), 32'(lat_hi[k]), 32'(lh));
    check($sformatf("%s.lat_lo[%0d]", ph, k), 32'(lat_lo[k]), 32'(ll));
    check($sformatf("%s.ce_n[%0d]",   ph, k), 32'(ce_n[k]),   32'(ce));
    check($sformatf("%s.oe_n[%0d]",   ph, k), 32'(oe_n[k]),   32'(oe));
    check($sformatf("%s.we_n[%0d]",   ph, k), 32'(we_n[k]),   32'(we));
    check($sformatf("%s.douten[%0d]", ph, k), 32'(douten[k]), 32'(en));
    check($sformatf("%s.ack[%0d]",    ph, k), 32'(ack[k]),    32'(ak));
    check($sformatf("%s.dout[%0d]",   ph, k), 32'(dout[k]),   32'(d));
  endtask

  task automatic reset_model();
    for (int j = 0; j < N; j++) begin
      hv[j] = 1'b0; ha[j] = '0; mdtr[j] = '0; mdout[j] = '0;
    end
  endtask

  // One transaction, entered and left at a negedge with the instance in IDLE
  task automatic txn(int k, bit rw, logic [31:0] a, logic [31:0] d, bit hold, bit abort);
    cyc_t q[$];
    cyc_t c;
    bit skip;
    logic [15:0] cur;
    logic [31:0] rd;
    int s, lat;
    s = (k == 2) ? 2 : 0;

    chk_outs(k, "idle", 0, 0, 1, 1, 1, 0, 0, mdout[k]);
    check($sformatf("idle.dtr[%0d]", k), dtr[k], mdtr[k]);

    skip = (k != 0) && hv[k] && (a[31:16] == ha[k]);
    cur  = mdout[k];
    if (!skip) begin
      c = '{lh:1, ll:0, ce:1, oe:1, we:1, en:1, ak:0, d:a[31:16], dt:0, last:0, h:0};
      q.push_back(c);
    end
    for (int h = 0; h < 2; h++) begin
      cur = {a[15:2], h[0], 1'b0};
      c = '{lh:0, ll:1, ce:0, oe:1, we:1, en:1, ak:0, d:cur, dt:0, last:0, h:h[0]};
      q.push_back(c);
      for (int j = 0; j <= s; j++) begin
        if (rw) begin
          cur = (h == 0) ? d[31:16] : d[15:0];
          c = '{lh:0, ll:0, ce:0, oe:1, we:0, en:1, ak:0, d:cur, dt:1, last:(j == s), h:h[0]};
        end else begin
          c = '{lh:0, ll:0, ce:0, oe:0, we:1, en:0, ak:0, d:cur, dt:1, last:(j == s), h:h[0]};
        end
        q.push_back(c);
      end
    end
    c = '{lh:0, ll:0, ce:1, oe:1, we:1, en:0, ak:1, d:cur, dt:0, last:0, h:0};
    q.push_back(c);

    stb[k] = 1'b1; i_rw[k] = rw; i_addr[k] = a; i_dtw[k] = d;
    @(posedge clk);
    if (!skip) begin hv[k] = 1'b1; ha[k] = a[31:16]; end
    lat = -1;
    rd  = mdtr[k];
    foreach (q[i]) begin
      @(negedge clk);
      if (i == 0) begin
        stb[k] = hold; i_rw[k] = 1'($urandom); i_addr[k] = $urandom; i_dtw[k] = $urandom;
      end
      if (ack[k] === 1'b1 && lat < 0) lat = i;
      c = q[i];
      chk_outs(k, c.ak ? "done" : (c.dt ? "data" : "lat"),
               c.lh, c.ll, c.ce, c.oe, c.we, c.en, c.ak, c.d);
      if (c.ak) begin
        if (!rw) mdtr[k] = rd;
        check($sformatf("done.dtr[%0d]", k), dtr[k], mdtr[k]);
      end
      if (abort && c.dt) begin
        #2 reset = 1'b1;
        #1;
        reset_model();
        for (int j = 0; j < N; j++) begin
          chk_outs(j, "rst", 0, 0, 1, 1, 1, 0, 0, 16'h0);
          check($sformatf("rst.dtr[%0d]", j), dtr[j], 32'h0);
        end
        stb[k] = 1'b0;
        @(negedge clk) reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check($sformatf("noack[%0d]", k), 32'(ack[k]), 32'h0);
        end
        return;
      end
      din[k] = fixed_din ? 16'hABCD : 16'($urandom);
      if (c.last && !rw) begin
        if (c.h) rd[15:0] = din[k];
        else     rd[31:16] = din[k];
      end
    end
    mdout[k] = cur;
    check($sformatf("latency[%0d]", k), 32'(lat), 32'(skip ? 4 + 2 * s : 5 + 2 * s));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int n;
    reset = 1'b1;
    fixed_din = 1'b0;
    for (int k = 0; k < N; k++) begin
      stb[k] = 1'b0; i_rw[k] = 1'b0; i_addr[k] = '0; i_dtw[k] = '0; din[k] = '0;
    end
    reset_model();
    #12;
    for (int k = 0; k < N; k++) begin
      chk_outs(k, "por", 0, 0, 1, 1, 1, 0, 0, 16'h0);
      check($sformatf("por.dtr[%0d]", k), dtr[k], 32'h0);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    // Basic read and write, latching always
    fixed_din = 1'b1;
    txn(0, 0, 32'hAAAA_AAA1, 32'h0, 0, 0);
    txn(0, 1, 32'hAAAA_AAA1, 32'hABCD_1234, 0, 0);
    fixed_din = 1'b0;

    // Lazy upper-address latching
    txn(1, 0, 32'hAAAA_0000, 32'h0, 0, 0);
    txn(1, 0, 32'hAAAA_0010, 32'h0, 0, 0);
    txn(1, 0, 32'h5555_0000, 32'h0, 0, 0);

    // Wait states with din changing inside the data phase
    txn(2, 0, 32'h1234_5678, 32'h0, 0, 0);
    txn(2, 1, 32'h1234_0004, 32'hCAFE_F00D, 0, 0);

    // Reset during data phase, then the next access must relatch the upper address
    txn(1, 0, 32'h5555_0040, 32'h0, 0, 1);
    txn(1, 0, 32'h5555_0044, 32'h0, 0, 0);
    txn(2, 0, 32'h1234_0008, 32'h0, 0, 1);
    txn(2, 0, 32'h1234_000C, 32'h0, 0, 0);

    // Randomized traffic including stb held across back-to-back accesses
    for (int k = 0; k < N; k++) begin
      n = 24;
      for (int t = 0; t < n; t++) begin
        case ($urandom_range(0, 2))
          0:       a = {16'h1234, 16'($urandom)};
          1:       a = {16'h5678, 16'($urandom)};
          default: a = $urandom;
        endcase
        txn(k, 1'($urandom), a, $urandom, (t != n - 1) && ($urandom_range(0, 1) == 1), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
